// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - RV32 load/store target with configurable wait states.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses return rsp_err instead of aligning down.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        q_write;
  logic [31:0] q_addr;
  logic [2:0]  q_funct3;
  logic [31:0] q_wdata;

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  logic [31:0] offset;
  logic        in_range;
  logic [AW-1:0] idx;
  logic        misalign;
  logic        ld_ok;
  logic        st_ok;
  logic        acc_ok;
  logic [1:0]  lane;
  logic [31:0] word;
  logic [15:0] sh;
  logic [31:0] ld_data;
  logic [31:0] wr_word;
  logic [3:0]  be;
  logic        commit;

  assign req_ready = (state == IDLE);
  assign commit    = (state == WAIT) && (cnt == 4'd0);

  always_comb begin
    offset   = q_addr - BASE_ADDR;
    in_range = (q_addr >= BASE_ADDR) && ((offset >> 2) < 32'(DEPTH_WORDS));
    idx      = offset[AW+1:2];
    misalign = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    case (q_funct3[1:0])
      2'b01:   misalign = q_addr[0];
      2'b10:   misalign = |q_addr[1:0];
      default: misalign = 1'b0;
    endcase
`endif
    ld_ok  = !q_write && (q_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    st_ok  = q_write && (q_funct3 inside {3'b000, 3'b001, 3'b010});
    acc_ok = in_range && (ld_ok || st_ok) && !misalign;

    // Without the trap, half/word lanes are aligned down by construction here.
    case (q_funct3[1:0])
      2'b00:   lane = q_addr[1:0];
      2'b01:   lane = {q_addr[1], 1'b0};
      default: lane = 2'b00;
    endcase

    word = mem[idx];
    sh   = 16'(word >> {lane, 3'b000});
    case (q_funct3)
      3'b000:  ld_data = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
      3'b010:  ld_data = word;
      3'b100:  ld_data = {24'd0, sh[7:0]};
      3'b101:  ld_data = {16'd0, sh[15:0]};
      default: ld_data = 32'd0;
    endcase

    case (q_funct3[1:0])
      2'b00: begin
        be      = 4'b0001 << lane;
        wr_word = {4{q_wdata[7:0]}};
      end
      2'b01: begin
        be      = 4'b0011 << lane;
        wr_word = {2{q_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        wr_word = q_wdata;
      end
    endcase
  end

  // A reset on the commit edge drops the pending store.
  always_ff @(posedge clk) begin
    if (reset && commit && acc_ok && q_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      q_write   <= 1'b0;
      q_addr    <= 32'd0;
      q_funct3  <= 3'd0;
      q_wdata   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            q_write  <= req_write;
            q_addr   <= req_addr;
            q_funct3 <= req_funct3;
            q_wdata  <= req_wdata;
            cnt      <= 4'(WAIT_CYCLES);
            state    <= WAIT;
            busy     <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= !acc_ok;
            rsp_rdata <= (acc_ok && !q_write) ? ld_data : 32'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
